mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port synchronous block RAM between the instruction-fetch path and the data-move path of the core. Each requester presents a request with an address and is granted the memory for one cycle; read data returns one cycle after the grant with a valid strobe routed to the owner. Data accesses win by default, and a starvation counter guarantees fetch progress. Sits between the control datapath (fetch/data units) and a shared `bram` instance.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive lost contested cycles after which fetch is forced to win (1..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, held until if_gnt
- if_addr  in  AW  fetch address, stable while if_req
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data granted this cycle (write completes at this edge)
- d_rvalid  out  1  d_rdata valid (cycle after read grant)
- d_rdata  out  DW  data read data
- m_addr  out  AW  to bram i_addr
- m_write  out  1  to bram i_write
- m_wdata  out  DW  to bram i_data
- m_rdata  in  DW  from bram o_data, 1-cycle read latency

## Operation
- Grant decision combinational from current requests and registered arbitration state; at most one of if_gnt/d_gnt high per cycle.
- Only d_req: d_gnt=1. Only if_req: if_gnt=1. Neither: no grant, m_write=0, m_addr=0, m_wdata=0.
- Contention (both req), default policy: data wins unless starve_cnt == STARVE_MAX, then fetch wins.
- starve_cnt (4 bits): +1 when both request and data is granted; cleared on any if_gnt or when if_req=0; saturates at STARVE_MAX.
- Granted port drives m_addr (and m_write=d_we, m_wdata=d_wdata for data) in the grant cycle.
- owner register: records granted read (NONE/IF/D) at grant edge; next cycle raises matching rvalid; rdata outputs = m_rdata when that port's rvalid, else 0.
- Data writes: no rvalid; d_gnt edge is the commit.
- Requester may drop req or present a new request the cycle after gnt; back-to-back grants every cycle allowed.
- Request deasserted before grant: withdrawn, no side effects.

## Timing
- Reset (rst=0, async): if_gnt=d_gnt=0, if_rvalid=d_rvalid=0, rdata=0, m_write=0, m_addr=0, starve_cnt=0, owner=NONE, rr_last=IF.
- Grants forced 0 while rst=0; pending rvalid of an in-flight read dropped on reset mid-operation.
- Read latency: gnt in cycle N, rvalid and rdata in cycle N+1, single-cycle pulse.
- Grant in N+1 may overlap rvalid of grant N (pipelined, one per cycle).
- Worst-case fetch wait under continuous data traffic: STARVE_MAX cycles, granted in cycle STARVE_MAX+1.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on contention; rr_last register (updated on every grant) — contended grant goes to the port not granted last; starve_cnt and STARVE_MAX logic compiled out.
- Undefined: fixed data priority with starvation counter as above.

## Test plan
- Reset, then if_req=1 addr=0x10, bram holds 0xDEADBEEF -> if_gnt cycle 1, if_rvalid with if_rdata=0xDEADBEEF cycle 2, d_rvalid=0.
- d_req write addr=0x4 data=0x55, then read 0x4 -> d_gnt both, no rvalid on write, d_rvalid with 0x55 after read grant.
- Both requesting continuously, STARVE_MAX=4, default build -> 4 d_gnt, then if_gnt, pattern repeats; never both gnt high.
- Same stimulus with MEM_ARB_RR_EN -> grants alternate D, IF, D, IF.
- Read granted, rst pulled low before next edge -> if_rvalid/d_rvalid stay 0, all outputs at reset values, starve_cnt=0.
- if_req dropped before grant while d_req active -> no if_gnt, no if_rvalid, starve_cnt cleared.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous BRAM between the fetch and data-move paths.
// Optional build macro MEM_ARB_RR_EN: round-robin on contention instead of data priority with starvation guard.
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic [AW-1:0] m_addr,
   output logic          m_write,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic [3:0]    dbg_starve_cnt_o,
   output logic [1:0]    dbg_owner_o,
   output logic          dbg_rr_last_o
);

   // Handshake: a requester holds req (and its address/data) until it sees gnt in the
   // same cycle; the access happens at that edge. Dropping req before gnt withdraws it.
   // Reads return on the owner's rvalid exactly one cycle after gnt; writes never do.

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   typedef enum logic {
      LAST_IF = 1'b0,
      LAST_D  = 1'b1
   } last_e;

   owner_e owner_q, owner_d;
   last_e  rr_last_q, rr_last_d;
   logic   contend;
   logic   if_win;

   assign contend = if_req & d_req;

`ifdef MEM_ARB_RR_EN
   assign if_win           = (rr_last_q == LAST_D);
   assign dbg_starve_cnt_o = 4'd0;
`else
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_cnt_q, starve_cnt_d;

   assign if_win           = (starve_cnt_q == STARVE_LIM);
   assign dbg_starve_cnt_o = starve_cnt_q;

   // Counts only contested cycles fetch loses; any fetch grant or idle fetch clears it.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req || if_gnt) begin
         starve_cnt_d = 4'd0;
      end else if (contend && d_gnt && (starve_cnt_q != STARVE_LIM)) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_q <= 4'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`endif

   // Grants are held low while reset is asserted, independent of the clock.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (rst) begin
         if (contend) begin
            if_gnt = if_win;
            d_gnt  = ~if_win;
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   always_comb begin
      m_addr  = '0;
      m_write = 1'b0;
      m_wdata = '0;
      if (if_gnt) begin
         m_addr = if_addr;
      end else if (d_gnt) begin
         m_addr  = d_addr;
         m_write = d_we;
         m_wdata = d_wdata;
      end
   end

   always_comb begin
      owner_d   = OWN_NONE;
      rr_last_d = rr_last_q;
      if (if_gnt) begin
         owner_d   = OWN_IF;
         rr_last_d = LAST_IF;
      end else if (d_gnt) begin
         owner_d   = d_we ? OWN_NONE : OWN_D;
         rr_last_d = LAST_D;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q   <= OWN_NONE;
         rr_last_q <= LAST_IF;
      end else begin
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
      end
   end

   assign if_rvalid     = (owner_q == OWN_IF);
   assign d_rvalid      = (owner_q == OWN_D);
   assign if_rdata      = if_rvalid ? m_rdata : '0;
   assign d_rdata       = d_rvalid ? m_rdata : '0;
   assign dbg_owner_o   = owner_q;
   assign dbg_rr_last_o = rr_last_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small 1-cycle-latency BRAM model behind it.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic [AW-1:0] m_addr;
   logic          m_write;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic [3:0]    dbg_starve_cnt;
   logic [1:0]    dbg_owner;
   logic          dbg_rr_last;

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] exp_q [$];

   mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .if_req           (if_req),
      .if_addr          (if_addr),
      .if_gnt           (if_gnt),
      .if_rvalid        (if_rvalid),
      .if_rdata         (if_rdata),
      .d_req            (d_req),
      .d_we             (d_we),
      .d_addr           (d_addr),
      .d_wdata          (d_wdata),
      .d_gnt            (d_gnt),
      .d_rvalid         (d_rvalid),
      .d_rdata          (d_rdata),
      .m_addr           (m_addr),
      .m_write          (m_write),
      .m_wdata          (m_wdata),
      .m_rdata          (m_rdata),
      .dbg_starve_cnt_o (dbg_starve_cnt),
      .dbg_owner_o      (dbg_owner),
      .dbg_rr_last_o    (dbg_rr_last)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: write-on-edge, registered read of the presented address
   always @(posedge clk) begin
      if (m_write) mem[m_addr[7:0]] <= m_wdata;
      m_rdata <= mem[m_addr[7:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      tick();
   endtask

   initial begin : stim
      logic exp_if;
      logic prev_if;
      logic [DW-1:0] exp_rd;

      for (int k = 0; k < 256; k++) mem[k] = '0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h20] = 32'h1111_2222;
      mem[8'h30] = 32'h3333_4444;
      m_rdata = '0;

      // reset with both requesters active: nothing may be granted
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h99;
      #2;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_m_write", m_write, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_starve", dbg_starve_cnt, 0);
      check("rst_owner", dbg_owner, 0);
      check("rst_rr_last", dbg_rr_last, 0);
      tick();
      tick();
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
      rst = 1'b1;

      // fetch read of 0x10
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      check("f_if_gnt", if_gnt, 1);
      check("f_d_gnt", d_gnt, 0);
      check("f_m_addr", m_addr, 32'h10);
      check("f_m_write", m_write, 0);
      check("f_if_rvalid_early", if_rvalid, 0);
      tick();
      if_req = 1'b0;
      #1;
      check("f_if_rvalid", if_rvalid, 1);
      check("f_if_rdata", if_rdata, 32'hDEADBEEF);
      check("f_d_rvalid", d_rvalid, 0);
      check("f_d_rdata", d_rdata, 0);
      check("f_if_gnt_idle", if_gnt, 0);
      check("f_m_addr_idle", m_addr, 0);
      tick();
      check("f_if_rvalid_pulse", if_rvalid, 0);
      check("f_if_rdata_zero", if_rdata, 0);

      // data write 0x55 to 0x4, then read it back
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h55;
      #1;
      check("w_d_gnt", d_gnt, 1);
      check("w_if_gnt", if_gnt, 0);
      check("w_m_write", m_write, 1);
      check("w_m_addr", m_addr, 32'h4);
      check("w_m_wdata", m_wdata, 32'h55);
      tick();
      d_we = 1'b0; d_wdata = '0;
      #1;
      check("w_no_rvalid", d_rvalid, 0);
      check("r_d_gnt", d_gnt, 1);
      check("r_m_write", m_write, 0);
      check("r_m_addr", m_addr, 32'h4);
      check("r_m_wdata", m_wdata, 0);
      tick();
      d_req = 1'b0;
      #1;
      check("r_d_rvalid", d_rvalid, 1);
      check("r_d_rdata", d_rdata, 32'h55);
      check("r_if_rvalid", if_rvalid, 0);
      check("r_d_gnt_idle", d_gnt, 0);
      tick();
      check("r_d_rvalid_pulse", d_rvalid, 0);
      check("r_d_rdata_zero", d_rdata, 0);

      // continuous contention from a fresh reset
      do_reset();
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
      prev_if = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
`ifdef MEM_ARB_RR_EN
         exp_if = (i % 2 == 1);
         check("c_starve", dbg_starve_cnt, 0);
`else
         exp_if = (i % 5 == 4);
         check("c_starve", dbg_starve_cnt, 64'(i % 5));
`endif
         check("c_if_gnt", if_gnt, exp_if);
         check("c_d_gnt", d_gnt, !exp_if);
         check("c_one_hot", if_gnt & d_gnt, 0);
         check("c_m_addr", m_addr, exp_if ? 32'h20 : 32'h30);
         if (i > 0) begin
            exp_rd = exp_q.pop_front();
            check("c_if_rvalid", if_rvalid, prev_if);
            check("c_d_rvalid", d_rvalid, !prev_if);
            if (prev_if) check("c_if_rdata", if_rdata, exp_rd);
            else         check("c_d_rdata", d_rdata, exp_rd);
         end
         exp_q.push_back(exp_if ? 32'h1111_2222 : 32'h3333_4444);
         prev_if = exp_if;
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      exp_q.delete();
      tick();

      // reset asserted between a read grant and its return
      if_req = 1'b1; if_addr = 32'h10;
      #1;
      check("m_if_gnt", if_gnt, 1);
      #1;
      rst = 1'b0;
      #1;
      check("m_gnt_forced", if_gnt, 0);
      check("m_addr_forced", m_addr, 0);
      @(posedge clk);
      #1;
      check("m_if_rvalid", if_rvalid, 0);
      check("m_d_rvalid", d_rvalid, 0);
      check("m_if_rdata", if_rdata, 0);
      check("m_starve", dbg_starve_cnt, 0);
      check("m_owner", dbg_owner, 0);
      check("m_rr_last", dbg_rr_last, 0);
      if_req = 1'b0;
      rst = 1'b1;
      tick();

      // fetch withdraws while data keeps winning
      if_req = 1'b1; if_addr = 32'h20;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h30;
      #1;
      check("x_d_gnt", d_gnt, 1);
      check("x_if_gnt", if_gnt, 0);
      tick();
`ifdef MEM_ARB_RR_EN
      check("x_starve_one", dbg_starve_cnt, 0);
`else
      check("x_starve_one", dbg_starve_cnt, 1);
`endif
      if_req = 1'b0;
      #1;
      check("x_d_gnt2", d_gnt, 1);
      check("x_if_gnt2", if_gnt, 0);
      check("x_d_rvalid", d_rvalid, 1);
      check("x_d_rdata", d_rdata, 32'h3333_4444);
      tick();
      d_req = 1'b0;
      #1;
      check("x_starve_clr", dbg_starve_cnt, 0);
      check("x_if_rvalid", if_rvalid, 0);
      check("x_d_rvalid2", d_rvalid, 1);
      check("x_if_gnt3", if_gnt, 0);
      check("x_d_gnt3", d_gnt, 0);
      tick();
      check("x_d_rvalid_end", d_rvalid, 0);
      check("x_if_rvalid_end", if_rvalid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
